// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-atomic round-robin arbiter sharing one UDP TX
// metadata + data path among NUM_REQ requesters, with per-port packet counters.
module udp_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 512,
    parameter int META_WIDTH = 176,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                            net_clk,
    input  logic                            net_rst,
    input  logic [NUM_REQ-1:0]              s_meta_valid,
    output logic [NUM_REQ-1:0]              s_meta_ready,
    input  logic [NUM_REQ*META_WIDTH-1:0]   s_meta_data,
    input  logic [NUM_REQ-1:0]              s_data_valid,
    output logic [NUM_REQ-1:0]              s_data_ready,
    input  logic [NUM_REQ*WIDTH-1:0]        s_data_data,
    input  logic [NUM_REQ*WIDTH/8-1:0]      s_data_keep,
    input  logic [NUM_REQ-1:0]              s_data_last,
    output logic                            m_meta_valid,
    input  logic                            m_meta_ready,
    output logic [META_WIDTH-1:0]           m_meta_data,
    output logic                            m_data_valid,
    input  logic                            m_data_ready,
    output logic [WIDTH-1:0]                m_data_data,
    output logic [WIDTH/8-1:0]              m_data_keep,
    output logic                            m_data_last,
    output logic [IDW-1:0]                  grant_id,
    output logic                            busy,
    output logic [NUM_REQ*32-1:0]           pkt_count
);

    localparam int KW = WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] META = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]               state;
    logic [IDW-1:0]           rr_ptr;
    logic [NUM_REQ-1:0][31:0] pkt_cnt;
    logic                     any_req;
    logic [IDW-1:0]           pick;
    logic [IDW-1:0]           cand;
    logic                     sel_meta_valid;
    logic                     sel_data_valid;

    assign busy      = (state != IDLE);
    assign pkt_count = pkt_cnt;

    // Round-robin search from rr_ptr; scanning backwards lets the nearest requester win
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr;
        cand    = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (s_meta_valid[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // Steer the granted requester's metadata and data slices onto the shared outputs
    always_comb begin
        m_meta_data    = '0;
        m_data_data    = '0;
        m_data_keep    = '0;
        m_data_last    = 1'b0;
        sel_meta_valid = 1'b0;
        sel_data_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == grant_id) begin
                m_meta_data    = s_meta_data[i*META_WIDTH +: META_WIDTH];
                m_data_data    = s_data_data[i*WIDTH +: WIDTH];
                m_data_keep    = s_data_keep[i*KW +: KW];
                m_data_last    = s_data_last[i];
                sel_meta_valid = s_meta_valid[i];
                sel_data_valid = s_data_valid[i];
            end
        end
    end

    // Only the granted port sees ready, only in its phase, and nothing moves while in reset
    always_comb begin
        s_meta_ready = '0;
        s_data_ready = '0;
        m_meta_valid = 1'b0;
        m_data_valid = 1'b0;
        if (!net_rst) begin
            case (state)
                META: begin
                    m_meta_valid           = sel_meta_valid;
                    s_meta_ready[grant_id] = m_meta_ready;
                end
                DATA: begin
                    m_data_valid           = sel_data_valid;
                    s_data_ready[grant_id] = m_data_ready;
                end
                default: ;
            endcase
        end
    end

    // Grant/phase sequencing; the pointer advances and the counter bumps on the last beat
    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            pkt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick;
                        state    <= META;
                    end
                end
                META: begin
                    if (m_meta_valid && m_meta_ready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (m_data_valid && m_data_ready && m_data_last) begin
                        state             <= IDLE;
                        rr_ptr            <= IDW'((int'(grant_id) + 1) % NUM_REQ);
                        pkt_cnt[grant_id] <= pkt_cnt[grant_id] + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
